// File: rtl/cmp_pkg.sv
// Shared definitions for the registered magnitude comparator: one-hot result
// encoding ordered {G,E,L} and a one-hot legality check.
package cmp_pkg;

  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b100;

  function automatic logic cmp_is_onehot(input logic [2:0] res);
    return (res == CMP_LT) || (res == CMP_EQ) || (res == CMP_GT);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands, unsigned or
// two's-complement, producing the one-hot {gt, eq, lt} vector.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       cmp
);

  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned compare serves both modes without widening operands.
  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = SIGNED;
  end

  assign a_key = a ^ sign_flip;
  assign b_key = b ^ sign_flip;

  // NOTE: every path assigns cmp, so no latch is inferred.
  always_comb begin
    if (a == b)             cmp = CMP_EQ;
    else if (a_key > b_key) cmp = CMP_GT;
    else                    cmp = CMP_LT;
  end

endmodule

// File: rtl/two_bit_comparator.sv
// Registered magnitude comparator: captures a one-hot {G,E,L} result one cycle
// after each valid operand pair; results hold while idle.
module two_bit_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             G,
  output logic             E,
  output logic             L
);

  logic [2:0] cmp_next;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a   (a),
    .b   (b),
    .cmp (cmp_next)
  );

  // NOTE: sequential state uses non-blocking assignments; the missing else on
  // in_valid is a clock-enabled hold on the flops, not a latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      {G, E, L} <= 3'b000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) {G, E, L} <= cmp_next;
    end
  end

  a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> cmp_is_onehot({G, E, L}));

endmodule

// File: tb/tb_two_bit_comparator.sv
// Self-checking bench: three comparator instances (2-bit unsigned, 2-bit
// signed, 8-bit unsigned) checked against an integer-arithmetic reference.
module tb_two_bit_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;

  logic ov_u, g_u, e_u, l_u;
  logic ov_s, g_s, e_s, l_s;
  logic ov_8, g_8, e_8, l_8;

  logic [3:0] res_u, res_s, res_8;
  logic [3:0] exp_u, exp_s, exp_8;

  int checks = 0;
  int errors = 0;

  assign res_u = {ov_u, g_u, e_u, l_u};
  assign res_s = {ov_s, g_s, e_s, l_s};
  assign res_8 = {ov_8, g_8, e_8, l_8};

  two_bit_comparator #(.WIDTH(2), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a2), .b(b2),
    .out_valid(ov_u), .G(g_u), .E(e_u), .L(l_u));

  two_bit_comparator #(.WIDTH(2), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a2), .b(b2),
    .out_valid(ov_s), .G(g_s), .E(e_s), .L(l_s));

  two_bit_comparator #(.WIDTH(8), .SIGNED(1'b0)) dut_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov_8), .G(g_8), .E(e_8), .L(l_8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: interpret operands as integers and compare them numerically.
  function automatic logic [2:0] ref_cmp(input int unsigned av, input int unsigned bv,
                                         input int w, input bit sgn);
    longint x = longint'(av);
    longint y = longint'(bv);
    longint half = longint'(1) << (w - 1);
    longint span = longint'(1) << w;
    if (sgn) begin
      if (x >= half) x = x - span;
      if (y >= half) y = y - span;
    end
    if (x > y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {ov,G,E,L}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, then check all instances.
  task automatic step(input logic v, input logic [1:0] av, input logic [1:0] bv,
                      input logic [7:0] a8v, input logic [7:0] b8v);
    in_valid = v; a2 = av; b2 = bv; a8 = a8v; b8 = b8v;
    @(posedge clk);
    if (v) begin
      exp_u = {1'b1, ref_cmp(av, bv, 2, 1'b0)};
      exp_s = {1'b1, ref_cmp(av, bv, 2, 1'b1)};
      exp_8 = {1'b1, ref_cmp(a8v, b8v, 8, 1'b0)};
    end else begin
      exp_u[3] = 1'b0;
      exp_s[3] = 1'b0;
      exp_8[3] = 1'b0;
    end
    #1;
    check("u2_model", res_u, exp_u);
    check("s2_model", res_s, exp_s);
    check("u8_model", res_8, exp_8);
  endtask

  logic [1:0] seq_a [7];
  logic [1:0] seq_b [7];
  logic [3:0] seq_e [7];

  initial begin
    seq_a = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    seq_b = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    seq_e = '{4'b1010, 4'b1100, 4'b1010, 4'b1001, 4'b1010, 4'b1100, 4'b1010};

    // Reset held with valid inputs present: outputs must stay cleared.
    rst_n = 1'b0; in_valid = 1'b1; a2 = 2'd1; b2 = 2'd0; a8 = 8'd1; b8 = 8'd0;
    exp_u = '0; exp_s = '0; exp_8 = '0;
    #1;
    check("reset_async_u2", res_u, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold_u2", res_u, 4'b0000);
      check("reset_hold_s2", res_s, 4'b0000);
      check("reset_hold_u8", res_8, 4'b0000);
    end
    rst_n = 1'b1;
    step(1'b1, 2'd1, 2'd0, 8'd1, 8'd0);
    check("first_capture_u2", res_u, 4'b1100);

    // Directed unsigned sequence, one pair per cycle.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq_a[i], seq_b[i], 8'd0, 8'd0);
      check("unsigned_seq", res_u, seq_e[i]);
    end

    // Hold: results stay while idle, out_valid drops.
    step(1'b1, 2'd3, 2'd1, 8'd7, 8'd9);
    check("hold_capture", res_u, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 2'd3, 8'd0, 8'd255);
      check("hold_idle_u2", res_u, 4'b0100);
      check("hold_idle_u8", res_8, 4'b0001);
    end

    // Asynchronous reset between edges while G is set.
    step(1'b1, 2'd3, 2'd1, 8'd200, 8'd100);
    check("pre_reset_g", res_u, 4'b1100);
    #3 rst_n = 1'b0;
    #1;
    check("async_clear_u2", res_u, 4'b0000);
    check("async_clear_u8", res_8, 4'b0000);
    exp_u = '0; exp_s = '0; exp_8 = '0;
    @(posedge clk); #1;
    check("reset_edge_lost", res_u, 4'b0000);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 2'd3, 8'd0, 8'd1);
    check("post_reset_capture", res_u, 4'b1001);

    // Exhaustive 2-bit pairs, both signedness modes.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'(i >> 2), 2'(i & 3), 8'(i), 8'(15 - i));
    end

    // Named boundary points.
    step(1'b1, 2'd3, 2'd0, 8'd255, 8'd254);
    check("u2_3_vs_0", res_u, 4'b1100);
    check("u8_255_vs_254", res_8, 4'b1100);
    step(1'b1, 2'd0, 2'd3, 8'd0, 8'd255);
    check("u2_0_vs_3", res_u, 4'b1001);
    check("u8_0_vs_255", res_8, 4'b1001);
    step(1'b1, 2'd3, 2'd3, 8'd128, 8'd128);
    check("u2_3_eq_3", res_u, 4'b1010);
    check("u8_128_eq_128", res_8, 4'b1010);
    step(1'b1, 2'd2, 2'd1, 8'd1, 8'd2);
    check("s2_neg2_vs_pos1", res_s, 4'b1001);
    check("u2_2_vs_1", res_u, 4'b1100);

    // Randomized traffic with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
           8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/two_bit_comparator.md
Name: two_bit_comparator

Overview:
Registered magnitude comparator for two unsigned operands, default width 2 bits. Each valid input pair produces a one-hot result: G when a > b, E when a == b, L when a < b. The result is registered with one-cycle latency. The block is a leaf datapath element used wherever a small magnitude compare must be registered for timing.

Parameters:
WIDTH, 2, operand width in bits (legal range 1..32).
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  qualifies a and b for the current cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result registers updated on the previous edge.
G  output  1  registered a > b.
E  output  1  registered a == b.
L  output  1  registered a < b.

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, immediately, independent of clk):
  - G = 0, E = 0, L = 0, out_valid = 0.
  - Outputs hold these values until the first valid capture after release.
- Capture: on a rising clk edge with in_valid = 1:
  - G <= (a > b), E <= (a == b), L <= (a < b).
  - out_valid <= 1.
  - Latency is exactly 1 cycle, and a new pair is accepted every cycle.
- Idle: on a rising edge with in_valid = 0:
  - G, E and L hold their previous values.
  - out_valid <= 0.
- One-hot: after any capture, exactly one of G, E, L is 1. All three are 0 only after reset and before the first capture.
- Compare rule:
  - SIGNED = 0: plain unsigned magnitude.
  - SIGNED = 1: MSB is the sign bit. The block uses no carry-out and no width extension beyond WIDTH.
  - Equality ignores SIGNED.
- Boundaries, WIDTH = 2, SIGNED = 0:
  - a = 3, b = 0 gives G.
  - a = 0, b = 3 gives L.
  - a = b = 0 and a = b = 3 give E.
- Boundary, WIDTH = 2, SIGNED = 1: a = 2'b10 (-2) vs b = 2'b01 (+1) gives L.
- rst_n asserted mid-stream: the pending capture is lost, outputs clear immediately, and the first valid pair after release is captured normally.
- The block has no backpressure and no X-propagation handling. Inputs are sampled only when in_valid = 1.

Decomposition:
- Shared package cmp_pkg:
  - localparam encoding for the result, CMP_LT = 3'b001, CMP_EQ = 3'b010, CMP_GT = 3'b100, ordered {G,E,L}.
  - A function for the one-hot check, used by assertions.
- One combinational sub-module, cmp_core:
  - Inputs a, b, parameters WIDTH and SIGNED.
  - Produces the unregistered {gt, eq, lt} vector.
- The top level holds only the valid register and the three result flops.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1, a = 1, b = 0 -> G = E = L = 0, out_valid = 0 throughout. Deassert rst_n -> next edge gives G = 1, out_valid = 1.
- Unsigned sequence, WIDTH = 2, one pair per cycle: (0,0) (1,0) (1,1) (1,2) (2,2) (3,2) (3,3) -> one cycle later {G,E,L} = 010, 100, 010, 001, 010, 100, 010, with out_valid = 1 each cycle.
- Hold: capture a = 3, b = 1 (G = 1), then drive in_valid = 0 with a = 0, b = 3 for 4 cycles -> G stays 1, L stays 0, out_valid = 0.
- Async reset mid-stream: assert rst_n low between edges while G = 1 -> G, E, L, out_valid drop to 0 before the next clk edge.
- Exhaustive: all 16 (a,b) pairs for WIDTH = 2, SIGNED = 0 and SIGNED = 1 -> match the reference model, and the one-hot assertion holds on every out_valid cycle. This includes signed a = 2, b = 1 -> L = 1.
- Width sweep: WIDTH = 8, a = 255, b = 254 -> G. a = 0, b = 255 -> L. a = b = 128 -> E.
